ka_split_sched_22bit: RTL and testbench

//  Producer side of the 22-bit Karatsuba stage. Accepts one 22-bit operand pair and splits

---
 rtl/ka_pkg.sv | 15 +
 rtl/clmul_serial_11bit.sv | 52 +++++
 rtl/ka_split_sched_22bit.sv | 114 +++++++++++
 tb/tb_ka_split_sched_22bit.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/ka_pkg.sv
// Shared widths and FSM encoding for the 22-bit Karatsuba producer stage.
package ka_pkg;
    localparam int HALF_W = 11;
    localparam int OP_W   = 2 * HALF_W;
    localparam int PROD_W = 2 * HALF_W - 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        MUL_LO  = 3'd1,
        MUL_HI  = 3'd2,
        MUL_MID = 3'd3,
        FIN     = 3'd4,
        DONE    = 3'd5
    } state_t;
endpackage

// File: rtl/clmul_serial_11bit.sv
// Bit-serial carry-less 11x11 multiplier: one y bit per cycle after a load cycle.
module clmul_serial_11bit
    import ka_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [HALF_W-1:0] x,
    input  logic [HALF_W-1:0] y,
    output logic              busy,
    output logic              done,
    output logic [PROD_W-1:0] prod
);
    localparam int CNT_W = $clog2(HALF_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_W - 1);

    logic [PROD_W-1:0] r_x;
    logic [HALF_W-1:0] r_y;
    logic [PROD_W-1:0] r_acc;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_busy;
    logic [PROD_W-1:0] w_acc_next;

    assign w_acc_next = r_acc ^ (r_y[0] ? r_x : '0);

    // done and prod are combinational so the caller captures the product on the final iteration edge
    assign busy = r_busy;
    assign done = r_busy && (r_cnt == CNT_LAST);
    assign prod = w_acc_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x    <= '0;
            r_y    <= '0;
            r_acc  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (start) begin
            r_x    <= PROD_W'(x);
            r_y    <= y;
            r_acc  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            r_acc  <= w_acc_next;
            r_x    <= r_x << 1;
            r_y    <= r_y >> 1;
            r_cnt  <= r_cnt + CNT_W'(1);
            r_busy <= (r_cnt != CNT_LAST);
        end
    end
endmodule

// File: rtl/ka_split_sched_22bit.sv
// Karatsuba producer: splits a 22-bit operand pair and schedules three carry-less
// 11x11 products on one shared serial multiplier, presenting p_lo/p_mid/p_hi.
module ka_split_sched_22bit
    import ka_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   a_in,
    input  logic [OP_W-1:0]   b_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROD_W-1:0] p_lo,
    output logic [PROD_W-1:0] p_mid,
    output logic [PROD_W-1:0] p_hi
);
    state_t            r_state;
    state_t            w_state_next;
    logic [OP_W-1:0]   r_a;
    logic [OP_W-1:0]   r_b;
    logic [PROD_W-1:0] r_p_lo;
    logic [PROD_W-1:0] r_p_mid;
    logic [PROD_W-1:0] r_p_hi;

    logic              w_mul_start;
    logic              w_mul_busy;
    logic              w_mul_done;
    logic [HALF_W-1:0] w_mul_x;
    logic [HALF_W-1:0] w_mul_y;
    logic [PROD_W-1:0] w_mul_prod;

    clmul_serial_11bit u_clmul (
        .clk   (clk),
        .rst_n (rst_n),
        .start (w_mul_start),
        .x     (w_mul_x),
        .y     (w_mul_y),
        .busy  (w_mul_busy),
        .done  (w_mul_done),
        .prod  (w_mul_prod)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (in_valid)   w_state_next = MUL_LO;
            MUL_LO:  if (w_mul_done) w_state_next = MUL_HI;
            MUL_HI:  if (w_mul_done) w_state_next = MUL_MID;
            MUL_MID: if (w_mul_done) w_state_next = FIN;
            FIN:                     w_state_next = DONE;
            DONE:    if (out_ready)  w_state_next = IDLE;
            default:                 w_state_next = IDLE;
        endcase
    end

    // The first cycle of each MUL_* state (multiplier idle) is its load cycle
    always_comb begin
        in_ready    = (r_state == IDLE);
        out_valid   = (r_state == DONE);
        w_mul_start = 1'b0;
        w_mul_x     = r_a[HALF_W-1:0];
        w_mul_y     = r_b[HALF_W-1:0];
        case (r_state)
            MUL_LO: begin
                w_mul_start = !w_mul_busy;
            end
            MUL_HI: begin
                w_mul_start = !w_mul_busy;
                w_mul_x     = r_a[OP_W-1:HALF_W];
                w_mul_y     = r_b[OP_W-1:HALF_W];
            end
            MUL_MID: begin
                w_mul_start = !w_mul_busy;
                w_mul_x     = r_a[HALF_W-1:0] ^ r_a[OP_W-1:HALF_W];
                w_mul_y     = r_b[HALF_W-1:0] ^ r_b[OP_W-1:HALF_W];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_p_lo  <= '0;
            r_p_mid <= '0;
            r_p_hi  <= '0;
        end else begin
            if (r_state == IDLE && in_valid) begin
                r_a <= a_in;
                r_b <= b_in;
            end
            if (w_mul_done) begin
                case (r_state)
                    MUL_LO:  r_p_lo  <= w_mul_prod;
                    MUL_HI:  r_p_hi  <= w_mul_prod;
                    MUL_MID: r_p_mid <= w_mul_prod;
                    default: ;
                endcase
            end
            if (r_state == FIN) r_p_mid <= r_p_mid ^ r_p_lo ^ r_p_hi;
        end
    end

    assign p_lo  = r_p_lo;
    assign p_mid = r_p_mid;
    assign p_hi  = r_p_hi;
endmodule

// File: tb/tb_ka_split_sched_22bit.sv
// Self-checking bench for ka_split_sched_22bit: vector table, scoreboard queue,
// backpressure hold and mid-operation reset sequences.
module tb_ka_split_sched_22bit;
    import ka_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [OP_W-1:0]   a_in;
    logic [OP_W-1:0]   b_in;
    logic              out_valid;
    logic              out_ready;
    logic [PROD_W-1:0] p_lo;
    logic [PROD_W-1:0] p_mid;
    logic [PROD_W-1:0] p_hi;

    always #5 clk = ~clk;

    ka_split_sched_22bit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p_lo      (p_lo),
        .p_mid     (p_mid),
        .p_hi      (p_hi)
    );

    typedef struct {
        logic [21:0] a;
        logic [21:0] b;
        logic [20:0] lo;
        logic [20:0] mid;
        logic [20:0] hi;
        int          hold;
    } vec_t;

    localparam int N_VEC = 14;
    vec_t vecs [N_VEC];
    vec_t sb_q [$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [20:0] clmul11(input logic [10:0] x, input logic [10:0] y);
        logic [20:0] r = '0;
        for (int i = 0; i < 11; i++)
            if (y[i]) r = r ^ (21'(x) << i);
        return r;
    endfunction

    function automatic logic [42:0] clmul22(input logic [21:0] x, input logic [21:0] y);
        logic [42:0] r = '0;
        for (int i = 0; i < 22; i++)
            if (y[i]) r = r ^ (43'(x) << i);
        return r;
    endfunction

    function automatic logic [42:0] overlap(input logic [20:0] lo, input logic [20:0] mid,
                                            input logic [20:0] hi);
        return 43'(lo) ^ (43'(mid) << 11) ^ (43'(hi) << 22);
    endfunction

    task automatic run_op(input vec_t v);
        int   waits = 0;
        int   lat   = 0;
        vec_t e;
        while (!in_ready && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        check("in_ready_idle", in_ready, 1);
        if (!in_ready) return;
        a_in     = v.a;
        b_in     = v.b;
        in_valid = 1'b1;
        @(posedge clk);
        sb_q.push_back(v);
        @(negedge clk);
        in_valid = 1'b0;
        a_in     = 22'($urandom);
        b_in     = 22'($urandom);
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check("latency", lat, 37);
        e = sb_q.pop_front();
        if (!out_valid) return;
        // Backpressure: result must hold while further operand pairs are offered
        for (int i = 0; i < v.hold; i++) begin
            in_valid = 1'b1;
            a_in     = 22'($urandom);
            b_in     = 22'($urandom);
            check("hold_stable", {out_valid, in_ready, p_lo, p_mid, p_hi},
                  {1'b1, 1'b0, e.lo, e.mid, e.hi});
            @(posedge clk);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("out_valid", out_valid, 1);
        check("p_lo", p_lo, e.lo);
        check("p_mid", p_mid, e.mid);
        check("p_hi", p_hi, e.hi);
        check("combined43", overlap(p_lo, p_mid, p_hi), clmul22(e.a, e.b));
        $display("op a=%06h b=%06h p_lo=%06h p_mid=%06h p_hi=%06h lat=%0d hold=%0d",
                 e.a, e.b, p_lo, p_mid, p_hi, lat, v.hold);
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("out_valid_cleared", out_valid, 0);
        check("in_ready_after", in_ready, 1);
    endtask

    initial begin
        vecs[0] = '{a: 22'h000001, b: 22'h000001, lo: 21'h1,   mid: 21'h0,   hi: 21'h0, hold: 0};
        vecs[1] = '{a: 22'h3FFFFF, b: 22'h000001, lo: 21'h7FF, mid: 21'h7FF, hi: 21'h0, hold: 2};
        vecs[2] = '{a: 22'h000800, b: 22'h000800, lo: 21'h0,   mid: 21'h0,   hi: 21'h1, hold: 0};
        vecs[3] = '{a: 22'h000003, b: 22'h000003, lo: 21'h5,   mid: 21'h0,   hi: 21'h0, hold: 10};
        for (int i = 4; i < N_VEC; i++) begin
            vecs[i].a    = 22'($urandom);
            vecs[i].b    = 22'($urandom);
            vecs[i].lo   = clmul11(vecs[i].a[10:0], vecs[i].b[10:0]);
            vecs[i].hi   = clmul11(vecs[i].a[21:11], vecs[i].b[21:11]);
            vecs[i].mid  = clmul11(vecs[i].a[10:0] ^ vecs[i].a[21:11],
                                   vecs[i].b[10:0] ^ vecs[i].b[21:11]) ^ vecs[i].lo ^ vecs[i].hi;
            vecs[i].hold = int'($urandom_range(0, 3));
        end

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_in      = '0;
        b_in      = '0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_p_lo", p_lo, 0);
        check("rst_p_mid", p_mid, 0);
        check("rst_p_hi", p_hi, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < N_VEC; i++) run_op(vecs[i]);

        // Reset 20 edges into an operation: outputs clear at once, no result emerges
        a_in     = 22'h3FFFFF;
        b_in     = 22'h000001;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_products", {p_lo, p_mid, p_hi}, 63'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("postrst_out_valid", out_valid, 0);
        run_op(vecs[1]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
